// File: rtl/vga_box_overlay.sv
// rtl/vga_box_overlay.sv - solid box cursor drawn over a background, moved toward a handshaked target once per frame
module vga_box_overlay #(
  parameter int       H_ACTIVE = 640,
  parameter int       V_ACTIVE = 480,
  parameter int       BOX_W    = 32,
  parameter int       BOX_H    = 32,
  parameter int       STEP     = 4,
  parameter logic [2:0] BOX_RGB = 3'b100,
  parameter logic [2:0] BG_RGB  = 3'b001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] counter_x,
  input  logic [9:0] counter_y,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic [9:0] tgt_x,
  input  logic [9:0] tgt_y,
  output logic [2:0] rgb,
  output logic       h_sync,
  output logic       v_sync,
  output logic       busy
);

  localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  X_MAX  = 10'(H_ACTIVE - BOX_W);
  localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - BOX_H);
  localparam logic [9:0]  STEP_V = 10'(STEP);
  localparam logic [10:0] BOX_W11 = 11'(BOX_W);
  localparam logic [10:0] BOX_H11 = 11'(BOX_H);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] MOVING = 1'b1;

  logic [0:0] state;
  logic [9:0] pos_x, pos_y, tgt_x_q, tgt_y_q, pend_x, pend_y;
  logic       pend_v;
  logic       act_q, hit_q, hs_q, vs_q;
  logic       frame_tick, accept;
  logic [9:0] nxt_x, nxt_y, cmt_x, cmt_y, clamp_x, clamp_y;
  logic       in_x, in_y;

  // One axis step toward the target, limited to STEP, never overshooting.
  function automatic logic [9:0] step_to(input logic [9:0] p, input logic [9:0] t);
    logic [9:0] r;
    r = p;
    if (t > p)
      r = ((t - p) > STEP_V) ? p + STEP_V : t;
    else if (p > t)
      r = ((p - t) > STEP_V) ? p - STEP_V : t;
    return r;
  endfunction

  assign frame_tick = (counter_x == 10'd0) && (counter_y == V_ACT);
  assign tgt_ready  = ~pend_v;
  assign accept     = tgt_valid & ~pend_v;
  assign busy       = (state == MOVING) | pend_v;

  assign clamp_x = (tgt_x > X_MAX) ? X_MAX : tgt_x;
  assign clamp_y = (tgt_y > Y_MAX) ? Y_MAX : tgt_y;

  assign nxt_x = step_to(pos_x, tgt_x_q);
  assign nxt_y = step_to(pos_y, tgt_y_q);
  assign cmt_x = pend_v ? pend_x : tgt_x_q;
  assign cmt_y = pend_v ? pend_y : tgt_y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pos_x   <= '0;
      pos_y   <= '0;
      tgt_x_q <= '0;
      tgt_y_q <= '0;
      pend_x  <= '0;
      pend_y  <= '0;
      pend_v  <= 1'b0;
    end else begin
      if (frame_tick) begin
        pos_x   <= nxt_x;
        pos_y   <= nxt_y;
        tgt_x_q <= cmt_x;
        tgt_y_q <= cmt_y;
        state   <= ((nxt_x != cmt_x) || (nxt_y != cmt_y)) ? MOVING : IDLE;
      end
      // An accept can only happen while nothing is pending, so it never
      // collides with the commit clearing pend_v.
      if (accept) begin
        pend_x <= clamp_x;
        pend_y <= clamp_y;
        pend_v <= 1'b1;
      end else if (frame_tick) begin
        pend_v <= 1'b0;
      end
    end
  end

  assign in_x = ({1'b0, counter_x} >= {1'b0, pos_x}) &&
                ({1'b0, counter_x} <  ({1'b0, pos_x} + BOX_W11));
  assign in_y = ({1'b0, counter_y} >= {1'b0, pos_y}) &&
                ({1'b0, counter_y} <  ({1'b0, pos_y} + BOX_H11));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
      hit_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb   <= 3'b000;
    end else begin
      act_q <= (counter_x < H_ACT) && (counter_y < V_ACT);
      hit_q <= in_x && in_y;
      hs_q  <= h_sync_in;
      vs_q  <= v_sync_in;
      rgb   <= act_q ? (hit_q ? BOX_RGB : BG_RGB) : 3'b000;
    end
  end

  // Sync inputs already lag the counters by one cycle, so one register aligns them with rgb.
  assign h_sync = hs_q;
  assign v_sync = vs_q;

endmodule

// File: tb/tb_vga_box_overlay.sv
// tb/tb_vga_box_overlay.sv - directed self-checking bench for vga_box_overlay
module tb_vga_box_overlay;

  logic       clk;
  logic       rst_n;
  logic [9:0] counter_x, counter_y;
  logic       h_sync_in, v_sync_in;
  logic       tgt_valid, tgt_ready;
  logic [9:0] tgt_x, tgt_y;
  logic [2:0] rgb;
  logic       h_sync, v_sync, busy;

  int checks = 0;
  int errors = 0;
  int n;

  vga_box_overlay dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .counter_x (counter_x),
    .counter_y (counter_y),
    .h_sync_in (h_sync_in),
    .v_sync_in (v_sync_in),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_x     (tgt_x),
    .tgt_y     (tgt_y),
    .rgb       (rgb),
    .h_sync    (h_sync),
    .v_sync    (v_sync),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    counter_x = 10'd0;
    counter_y = 10'd480;
    step();
    counter_x = 10'd700;
    counter_y = 10'd500;
  endtask

  task automatic check_pix(input string tag, input int x, input int y, input logic [2:0] exp);
    counter_x = 10'(x);
    counter_y = 10'(y);
    step();
    step();
    chk(tag, {13'd0, rgb}, {13'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    counter_x = 10'd700;
    counter_y = 10'd500;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    tgt_valid = 1'b0;
    tgt_x = '0;
    tgt_y = '0;
    step();
    step();
    chk("rst_rgb", {13'd0, rgb}, 16'd0);
    chk("rst_hs", {15'd0, h_sync}, 16'd1);
    chk("rst_vs", {15'd0, v_sync}, 16'd1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_ready", {15'd0, tgt_ready}, 16'd1);
    rst_n = 1'b1;
    step();

    // Box at origin after reset
    check_pix("p0_0", 0, 0, 3'b100);
    check_pix("p31_31", 31, 31, 3'b100);
    check_pix("p32_0", 32, 0, 3'b001);
    check_pix("p0_32", 0, 32, 3'b001);
    check_pix("p639_479", 639, 479, 3'b001);
    check_pix("p640_0", 640, 0, 3'b000);
    check_pix("p5_500", 5, 500, 3'b000);
    check_pix("p1023", 1023, 1023, 3'b000);

    // Move to (100,50)
    counter_x = 10'd300;
    counter_y = 10'd200;
    tgt_valid = 1'b1;
    tgt_x = 10'd100;
    tgt_y = 10'd50;
    chk("t2_ready_pre", {15'd0, tgt_ready}, 16'd1);
    step();
    tgt_valid = 1'b0;
    chk("t2_ready_low", {15'd0, tgt_ready}, 16'd0);
    chk("t2_busy", {15'd0, busy}, 16'd1);
    tick();
    chk("t2_ready_back", {15'd0, tgt_ready}, 16'd1);
    chk("t2_busy_mov", {15'd0, busy}, 16'd1);
    check_pix("t2_commit_nomove", 0, 0, 3'b100);
    for (int i = 0; i < 24; i++) tick();
    chk("t2_busy24", {15'd0, busy}, 16'd1);
    check_pix("t2_95_50", 95, 50, 3'b001);
    check_pix("t2_96_50", 96, 50, 3'b100);
    tick();
    chk("t2_idle", {15'd0, busy}, 16'd0);
    check_pix("t2_99_50", 99, 50, 3'b001);
    check_pix("t2_100_50", 100, 50, 3'b100);
    check_pix("t2_131_81", 131, 81, 3'b100);
    check_pix("t2_132_50", 132, 50, 3'b001);
    check_pix("t2_100_82", 100, 82, 3'b001);
    check_pix("t2_100_49", 100, 49, 3'b001);

    // Clamped target (700,470) -> (608,448)
    tgt_valid = 1'b1;
    tgt_x = 10'd700;
    tgt_y = 10'd470;
    step();
    tgt_valid = 1'b0;
    tick();
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("t3_moves", 16'(n), 16'd127);
    check_pix("t3_608_448", 608, 448, 3'b100);
    check_pix("t3_639_479", 639, 479, 3'b100);
    check_pix("t3_607_448", 607, 448, 3'b001);
    check_pix("t3_608_447", 608, 447, 3'b001);
    check_pix("t3_640_479", 640, 479, 3'b000);

    // Valid held while pending
    tgt_valid = 1'b1;
    tgt_x = 10'd10;
    tgt_y = 10'd10;
    step();
    tgt_x = 10'd20;
    tgt_y = 10'd20;
    chk("t4_ready0", {15'd0, tgt_ready}, 16'd0);
    step();
    step();
    chk("t4_ready_hold", {15'd0, tgt_ready}, 16'd0);
    tick();
    chk("t4_ready_after_commit", {15'd0, tgt_ready}, 16'd1);
    step();
    chk("t4_second_accept", {15'd0, tgt_ready}, 16'd0);
    tgt_valid = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk("t4_idle", {15'd0, busy}, 16'd0);
    check_pix("t4_20_20", 20, 20, 3'b100);
    check_pix("t4_19_20", 19, 20, 3'b001);
    check_pix("t4_20_19", 20, 19, 3'b001);

    // Offer exactly on a frame_tick
    tgt_valid = 1'b1;
    tgt_x = 10'd40;
    tgt_y = 10'd20;
    tick();
    tgt_valid = 1'b0;
    chk("t5_accepted", {15'd0, tgt_ready}, 16'd0);
    tick();
    chk("t5_committed", {15'd0, tgt_ready}, 16'd1);
    check_pix("t5_20_20", 20, 20, 3'b100);
    check_pix("t5_19_20", 19, 20, 3'b001);
    tick();
    check_pix("t5_23_20", 23, 20, 3'b001);
    check_pix("t5_24_20", 24, 20, 3'b100);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("t5_idle", {15'd0, busy}, 16'd0);

    // Alignment: sync latency and box edge latency (pos_x = 40)
    h_sync_in = 1'b0;
    chk("t6_hs_pre", {15'd0, h_sync}, 16'd1);
    step();
    chk("t6_hs_lat", {15'd0, h_sync}, 16'd0);
    v_sync_in = 1'b0;
    step();
    chk("t6_vs_lat", {15'd0, v_sync}, 16'd0);
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    counter_x = 10'd39;
    counter_y = 10'd20;
    step();
    counter_x = 10'd40;
    step();
    chk("t6_edge_1clk", {13'd0, rgb}, 16'd1);
    step();
    chk("t6_edge_2clk", {13'd0, rgb}, 16'd4);

    // Mid-frame asynchronous reset
    h_sync_in = 1'b0;
    step();
    chk("t6_hs_low", {15'd0, h_sync}, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rgb", {13'd0, rgb}, 16'd0);
    chk("t6_rst_hs", {15'd0, h_sync}, 16'd1);
    chk("t6_rst_vs", {15'd0, v_sync}, 16'd1);
    step();
    rst_n = 1'b1;
    h_sync_in = 1'b1;
    check_pix("t6_after_rst_0_0", 0, 0, 3'b100);
    check_pix("t6_after_rst_40_20", 40, 20, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
